// File: rtl/ledger_telemetry_pkg.sv
// Shared types for the ledger telemetry block: FSM state and snapshot record.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package ledger_telemetry_pkg;

    localparam int SNAP_BAL_W = 64;
    localparam int SNAP_CNT_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tele_state_t;

    typedef struct packed {
        logic [SNAP_CNT_W-1:0] window_id;
        logic [SNAP_CNT_W-1:0] tx_count;
        logic [SNAP_CNT_W-1:0] ok_count;
        logic [SNAP_CNT_W-1:0] fail_count;
        logic [SNAP_BAL_W-1:0] usdc_delta;
        logic [SNAP_BAL_W-1:0] gpu_delta;
        logic                  partial;
    } snap_t;

endpackage

// File: rtl/tele_snapshot_reg.sv
// Single-entry snapshot hold register with a count of snapshots lost while full.
// Latency: load visible on t_* one cycle after load_vld.
// Backpressure: holds until t_valid&&t_ready; loads arriving while held are dropped and counted.
module tele_snapshot_reg
    import ledger_telemetry_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_vld,
    input  snap_t                load_dat,
    input  logic                 t_ready,
    output logic                 t_valid,
    output snap_t                t_dat,
    output logic [CNT_WIDTH-1:0] t_dropped
);

    logic [CNT_WIDTH-1:0] drop_cnt;
    logic                 hs;
    logic                 load_ok;

    assign hs      = t_valid && t_ready;
    assign load_ok = load_vld && (!t_valid || hs);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_valid   <= 1'b0;
            t_dat     <= '0;
            t_dropped <= '0;
            drop_cnt  <= '0;
        end else if (load_ok) begin
            t_valid   <= 1'b1;
            t_dat     <= load_dat;
            t_dropped <= drop_cnt;
            drop_cnt  <= '0;
        end else if (load_vld) begin
            // Register is full and not draining this cycle: the new snapshot is lost.
            if (!(&drop_cnt)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end else if (hs) begin
            t_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ledger_telemetry.sv
// Windowed ledger result counters and fee-vault deltas, emitted as snapshots.
// Latency: snapshot on t_* one cycle after the window closes.
// Backpressure: single-entry output; closes while it is held are dropped and counted.
module ledger_telemetry
    import ledger_telemetry_pkg::*;
#(
    parameter int          BALANCE_WIDTH = 64,
    parameter int          CNT_WIDTH     = 32,
    parameter int unsigned WINDOW_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_enable,
    input  logic                     r_valid,
    input  logic                     r_success,
    input  logic [BALANCE_WIDTH-1:0] r_vault_usdc,
    input  logic [BALANCE_WIDTH-1:0] r_vault_gpu,
    output logic                     t_valid,
    input  logic                     t_ready,
    output logic [CNT_WIDTH-1:0]     t_window_id,
    output logic [CNT_WIDTH-1:0]     t_tx_count,
    output logic [CNT_WIDTH-1:0]     t_ok_count,
    output logic [CNT_WIDTH-1:0]     t_fail_count,
    output logic [BALANCE_WIDTH-1:0] t_usdc_delta,
    output logic [BALANCE_WIDTH-1:0] t_gpu_delta,
    output logic                     t_partial,
    output logic [CNT_WIDTH-1:0]     t_dropped
);

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(WINDOW_CYCLES - 1);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                     input logic                 inc);
        return (inc && !(&v)) ? v + 1'b1 : v;
    endfunction

    tele_state_t state, state_nxt;
    logic                     start, close, partial;
    logic [CNT_WIDTH-1:0]     timer, win_id;
    logic [CNT_WIDTH-1:0]     tx_cnt, ok_cnt, fail_cnt;
    logic [CNT_WIDTH-1:0]     tx_now, ok_now, fail_now;
    logic [BALANCE_WIDTH-1:0] base_usdc, base_gpu;
    snap_t                    snap, snap_q;

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        close     = 1'b0;
        partial   = 1'b0;
        case (state)
            IDLE: begin
                if (s_enable) begin
                    state_nxt = RUN;
                    start     = 1'b1;
                end
            end
            RUN: begin
                if (!s_enable) begin
                    state_nxt = IDLE;
                    close     = 1'b1;
                    partial   = 1'b1;
                end else if (timer == LAST) begin
                    close = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The start cycle counts its own result on top of freshly cleared counters.
    assign tx_now   = sat_inc(start ? '0 : tx_cnt,   r_valid);
    assign ok_now   = sat_inc(start ? '0 : ok_cnt,   r_valid && r_success);
    assign fail_now = sat_inc(start ? '0 : fail_cnt, r_valid && !r_success);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            timer     <= '0;
            win_id    <= '0;
            tx_cnt    <= '0;
            ok_cnt    <= '0;
            fail_cnt  <= '0;
            base_usdc <= '0;
            base_gpu  <= '0;
        end else begin
            state <= state_nxt;
            if (start) begin
                timer     <= '0;
                base_usdc <= r_vault_usdc;
                base_gpu  <= r_vault_gpu;
                tx_cnt    <= tx_now;
                ok_cnt    <= ok_now;
                fail_cnt  <= fail_now;
            end else if (close) begin
                timer     <= '0;
                base_usdc <= r_vault_usdc;
                base_gpu  <= r_vault_gpu;
                tx_cnt    <= '0;
                ok_cnt    <= '0;
                fail_cnt  <= '0;
                win_id    <= win_id + 1'b1;
            end else if (state == RUN) begin
                timer    <= timer + 1'b1;
                tx_cnt   <= tx_now;
                ok_cnt   <= ok_now;
                fail_cnt <= fail_now;
            end
        end
    end

    always_comb begin
        snap            = '0;
        snap.window_id  = SNAP_CNT_W'(win_id);
        snap.tx_count   = SNAP_CNT_W'(tx_now);
        snap.ok_count   = SNAP_CNT_W'(ok_now);
        snap.fail_count = SNAP_CNT_W'(fail_now);
        snap.usdc_delta = SNAP_BAL_W'(r_vault_usdc - base_usdc);
        snap.gpu_delta  = SNAP_BAL_W'(r_vault_gpu - base_gpu);
        snap.partial    = partial;
    end

    tele_snapshot_reg #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_snap_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_vld  (close),
        .load_dat  (snap),
        .t_ready   (t_ready),
        .t_valid   (t_valid),
        .t_dat     (snap_q),
        .t_dropped (t_dropped)
    );

    assign t_window_id  = CNT_WIDTH'(snap_q.window_id);
    assign t_tx_count   = CNT_WIDTH'(snap_q.tx_count);
    assign t_ok_count   = CNT_WIDTH'(snap_q.ok_count);
    assign t_fail_count = CNT_WIDTH'(snap_q.fail_count);
    assign t_usdc_delta = BALANCE_WIDTH'(snap_q.usdc_delta);
    assign t_gpu_delta  = BALANCE_WIDTH'(snap_q.gpu_delta);
    assign t_partial    = snap_q.partial;

endmodule

// File: tb/tb_ledger_telemetry.sv
// Bench for ledger_telemetry: vector table, directed corner sequences, random run vs reference model.
module tb_ledger_telemetry;

    localparam int BW = 64;
    localparam int CW = 32;
    localparam int WC = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_enable = 1'b0;
    logic          r_valid = 1'b0;
    logic          r_success = 1'b0;
    logic [BW-1:0] r_vault_usdc = '0;
    logic [BW-1:0] r_vault_gpu = '0;
    logic          t_ready = 1'b0;
    logic          t_valid;
    logic [CW-1:0] t_window_id, t_tx_count, t_ok_count, t_fail_count, t_dropped;
    logic [BW-1:0] t_usdc_delta, t_gpu_delta;
    logic          t_partial;

    always #5 clk = ~clk;

    ledger_telemetry #(
        .BALANCE_WIDTH (BW),
        .CNT_WIDTH     (CW),
        .WINDOW_CYCLES (WC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_enable     (s_enable),
        .r_valid      (r_valid),
        .r_success    (r_success),
        .r_vault_usdc (r_vault_usdc),
        .r_vault_gpu  (r_vault_gpu),
        .t_valid      (t_valid),
        .t_ready      (t_ready),
        .t_window_id  (t_window_id),
        .t_tx_count   (t_tx_count),
        .t_ok_count   (t_ok_count),
        .t_fail_count (t_fail_count),
        .t_usdc_delta (t_usdc_delta),
        .t_gpu_delta  (t_gpu_delta),
        .t_partial    (t_partial),
        .t_dropped    (t_dropped)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a window is a list of cycles; a snapshot is its sums and vault differences.
    bit            m_run;
    int            m_timer;
    logic [CW-1:0] m_tx, m_ok, m_fail, m_wid, m_drop;
    logic [BW-1:0] m_bu, m_bg;
    bit            o_valid, o_part;
    logic [CW-1:0] o_id, o_tx, o_ok, o_fail, o_drop;
    logic [BW-1:0] o_du, o_dg;

    function automatic logic [CW-1:0] sat(input logic [CW-1:0] x, input bit inc);
        return (inc && x != 32'hFFFF_FFFF) ? x + 32'd1 : x;
    endfunction

    task automatic model_reset();
        m_run = 0; m_timer = 0;
        m_tx = '0; m_ok = '0; m_fail = '0; m_wid = '0; m_drop = '0;
        m_bu = '0; m_bg = '0;
        o_valid = 0; o_part = 0;
        o_id = '0; o_tx = '0; o_ok = '0; o_fail = '0; o_drop = '0; o_du = '0; o_dg = '0;
    endtask

    task automatic model_step();
        bit            hs, formed, f_part;
        logic [CW-1:0] f_id, f_tx, f_ok, f_fail;
        logic [BW-1:0] f_du, f_dg;
        hs = o_valid && t_ready;
        formed = 0; f_part = 0;
        f_id = '0; f_tx = '0; f_ok = '0; f_fail = '0; f_du = '0; f_dg = '0;
        if (!m_run) begin
            if (s_enable) begin
                m_run = 1; m_timer = 0;
                m_bu = r_vault_usdc; m_bg = r_vault_gpu;
                m_tx = sat('0, r_valid);
                m_ok = sat('0, r_valid && r_success);
                m_fail = sat('0, r_valid && !r_success);
            end
        end else begin
            m_tx = sat(m_tx, r_valid);
            m_ok = sat(m_ok, r_valid && r_success);
            m_fail = sat(m_fail, r_valid && !r_success);
            if (!s_enable || m_timer == WC - 1) begin
                formed = 1; f_part = !s_enable;
                f_id = m_wid; f_tx = m_tx; f_ok = m_ok; f_fail = m_fail;
                f_du = r_vault_usdc - m_bu; f_dg = r_vault_gpu - m_bg;
                m_wid = m_wid + 32'd1;
                m_bu = r_vault_usdc; m_bg = r_vault_gpu;
                m_tx = '0; m_ok = '0; m_fail = '0; m_timer = 0;
                m_run = s_enable;
            end else begin
                m_timer++;
            end
        end
        if (formed && (!o_valid || hs)) begin
            o_valid = 1; o_part = f_part;
            o_id = f_id; o_tx = f_tx; o_ok = f_ok; o_fail = f_fail; o_du = f_du; o_dg = f_dg;
            o_drop = m_drop; m_drop = '0;
        end else if (formed) begin
            m_drop = sat(m_drop, 1);
        end else if (hs) begin
            o_valid = 0;
        end
    endtask

    task automatic cmp_model();
        chk1("t_valid", t_valid, o_valid);
        if (o_valid) begin
            chk32("t_window_id", t_window_id, o_id);
            chk32("t_tx_count", t_tx_count, o_tx);
            chk32("t_ok_count", t_ok_count, o_ok);
            chk32("t_fail_count", t_fail_count, o_fail);
            chk64("t_usdc_delta", t_usdc_delta, o_du);
            chk64("t_gpu_delta", t_gpu_delta, o_dg);
            chk1("t_partial", t_partial, o_part);
            chk32("t_dropped", t_dropped, o_drop);
        end
    endtask

    task automatic cyc(input bit en, input bit v, input bit s,
                       input logic [BW-1:0] vu, input logic [BW-1:0] vg, input bit rdy);
        s_enable = en; r_valid = v; r_success = s;
        r_vault_usdc = vu; r_vault_gpu = vg; t_ready = rdy;
        @(posedge clk);
        model_step();
        #1;
        cmp_model();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s_enable = 0; r_valid = 0; r_success = 0; t_ready = 0;
        r_vault_usdc = '0; r_vault_gpu = '0;
        model_reset();
        #2;
        chk1("rst t_valid", t_valid, 1'b0);
        chk1("rst t_partial", t_partial, 1'b0);
        chk32("rst t_window_id", t_window_id, 32'd0);
        chk32("rst t_tx_count", t_tx_count, 32'd0);
        chk32("rst t_dropped", t_dropped, 32'd0);
        chk64("rst t_usdc_delta", t_usdc_delta, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    typedef struct {
        bit            en, v, s;
        logic [BW-1:0] vu, vg;
        bit            rdy, ev;
        logic [CW-1:0] eid, etx, eok, efail;
        logic [BW-1:0] edu, edg;
        bit            ep;
    } vec_t;

    function automatic vec_t row(input bit en, input bit v, input bit s,
                                 input logic [BW-1:0] vu, input logic [BW-1:0] vg);
        vec_t r;
        r.en = en; r.v = v; r.s = s; r.vu = vu; r.vg = vg; r.rdy = 1;
        r.ev = 0; r.eid = '0; r.etx = '0; r.eok = '0; r.efail = '0;
        r.edu = '0; r.edg = '0; r.ep = 0;
        return r;
    endfunction

    vec_t          vec [10];
    logic [BW-1:0] vu, vg;

    initial begin
        // Basic window: 3 ok + 2 fail, vault 0/0 -> 10/4, last result on the closing cycle.
        vec[0] = row(1, 1, 1, 64'd0, 64'd0);
        vec[1] = row(1, 1, 0, 64'd1, 64'd0);
        vec[2] = row(1, 1, 1, 64'd2, 64'd1);
        vec[3] = row(1, 1, 0, 64'd3, 64'd1);
        vec[4] = row(1, 0, 0, 64'd4, 64'd2);
        vec[5] = row(1, 0, 0, 64'd5, 64'd2);
        vec[6] = row(1, 0, 0, 64'd6, 64'd3);
        vec[7] = row(1, 0, 0, 64'd8, 64'd3);
        vec[8] = row(1, 1, 1, 64'd10, 64'd4);
        vec[8].ev = 1; vec[8].eid = 32'd0; vec[8].etx = 32'd5; vec[8].eok = 32'd3;
        vec[8].efail = 32'd2; vec[8].edu = 64'd10; vec[8].edg = 64'd4; vec[8].ep = 0;
        vec[9] = row(1, 0, 0, 64'd11, 64'd4);

        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc(vec[i].en, vec[i].v, vec[i].s, vec[i].vu, vec[i].vg, vec[i].rdy);
            chk1("tbl valid", t_valid, vec[i].ev);
            if (vec[i].ev) begin
                chk32("tbl id", t_window_id, vec[i].eid);
                chk32("tbl tx", t_tx_count, vec[i].etx);
                chk32("tbl ok", t_ok_count, vec[i].eok);
                chk32("tbl fail", t_fail_count, vec[i].efail);
                chk64("tbl usdc", t_usdc_delta, vec[i].edu);
                chk64("tbl gpu", t_gpu_delta, vec[i].edg);
                chk1("tbl partial", t_partial, vec[i].ep);
            end
        end

        // Delta wraps modulo 2^64.
        do_reset();
        cyc(1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd0, 1);
        for (int i = 0; i < 7; i++) cyc(1, 0, 0, 64'd0, 64'd0, 1);
        cyc(1, 0, 0, 64'd5, 64'd0, 1);
        chk1("wrap valid", t_valid, 1'b1);
        chk64("wrap usdc_delta", t_usdc_delta, 64'd8);

        // Three closes under backpressure, then release.
        do_reset();
        cyc(1, 0, 0, 64'd0, 64'd0, 0);
        for (int i = 0; i < 3 * WC; i++) cyc(1, 0, 0, 64'd0, 64'd0, 0);
        chk1("hold valid", t_valid, 1'b1);
        chk32("hold id", t_window_id, 32'd0);
        for (int i = 0; i < WC; i++) cyc(1, 0, 0, 64'd0, 64'd0, 1);
        chk1("release valid", t_valid, 1'b1);
        chk32("release id", t_window_id, 32'd3);
        chk32("release dropped", t_dropped, 32'd2);

        // Partial window on enable drop at timer 3; IDLE ignores results.
        do_reset();
        cyc(1, 0, 0, 64'd0, 64'd0, 1);
        cyc(1, 1, 1, 64'd0, 64'd0, 1);
        cyc(1, 1, 0, 64'd0, 64'd0, 1);
        cyc(1, 0, 0, 64'd0, 64'd0, 1);
        cyc(0, 0, 0, 64'd7, 64'd0, 1);
        chk1("partial flag", t_partial, 1'b1);
        chk32("partial tx", t_tx_count, 32'd2);
        chk64("partial usdc", t_usdc_delta, 64'd7);
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 64'd0, 64'd0, 1);
        cyc(1, 0, 0, 64'd0, 64'd0, 1);
        for (int i = 0; i < WC; i++) cyc(1, 0, 0, 64'd0, 64'd0, 1);
        chk32("after idle tx", t_tx_count, 32'd0);
        chk32("after idle id", t_window_id, 32'd1);
        chk1("after idle partial", t_partial, 1'b0);

        // Results on the closing cycle and the one after land in separate windows; reset mid-hold.
        do_reset();
        cyc(1, 0, 0, 64'd0, 64'd0, 1);
        for (int i = 0; i < WC - 1; i++) cyc(1, 0, 0, 64'd0, 64'd0, 1);
        cyc(1, 1, 1, 64'd0, 64'd0, 1);
        chk32("edge w0 tx", t_tx_count, 32'd1);
        chk32("edge w0 ok", t_ok_count, 32'd1);
        cyc(1, 1, 0, 64'd0, 64'd0, 1);
        for (int i = 0; i < WC - 1; i++) cyc(1, 0, 0, 64'd0, 64'd0, 1);
        chk32("edge w1 id", t_window_id, 32'd1);
        chk32("edge w1 tx", t_tx_count, 32'd1);
        chk32("edge w1 fail", t_fail_count, 32'd1);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 64'd0, 64'd0, 0);
        chk1("pre-reset valid", t_valid, 1'b1);
        do_reset();
        cyc(1, 0, 0, 64'd0, 64'd0, 1);
        for (int i = 0; i < WC; i++) cyc(1, 0, 0, 64'd0, 64'd0, 1);
        chk1("post-reset valid", t_valid, 1'b1);
        chk32("post-reset id", t_window_id, 32'd0);

        // Random traffic against the model, vault starting near the wrap point.
        do_reset();
        vu = 64'hFFFF_FFFF_FFFF_FF00;
        vg = 64'd0;
        for (int i = 0; i < 600; i++) begin
            bit en, v, s, rdy;
            en  = ($urandom_range(0, 15) != 0);
            v   = ($urandom_range(0, 1) == 1);
            s   = ($urandom_range(0, 2) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            vu  = vu + 64'($urandom_range(0, 50));
            vg  = vg + 64'($urandom_range(0, 9));
            cyc(en, v, s, vu, vg, rdy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
